// File: rtl/taillight_request_arbiter_if.sv
// Switch inputs and controller-facing request outputs of the taillight request arbiter.
// The arbiter connects through the slave modport; the block driving the switches uses master.
interface taillight_request_arbiter_if;
  logic       raw_left;
  logic       raw_right;
  logic       raw_hazard;
  logic       raw_brake;
  logic       turn_left;
  logic       turn_right;
  logic       brake;
  logic       hazard_active;
  logic [1:0] seq_phase;

  modport master (
    output raw_left, raw_right, raw_hazard, raw_brake,
    input  turn_left, turn_right, brake, hazard_active, seq_phase
  );

  modport slave (
    input  raw_left, raw_right, raw_hazard, raw_brake,
    output turn_left, turn_right, brake, hazard_active, seq_phase
  );
endinterface

// File: rtl/taillight_request_arbiter.sv
// Conditions the raw stalk/hazard/brake switches and arbitrates turn and hazard requests.
// Each granted request is held for whole blink sequences, in step with taillight_controller.
module taillight_request_arbiter #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int STEP_CYCLES     = 5,
  parameter int STEPS           = 4,
  parameter int MIN_SEQS        = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  taillight_request_arbiter_if.slave bus
);

  localparam int NIN    = 4;
  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int CNT_W  = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int STEP_W = 2;
  localparam int SEQS_W = (MIN_SEQS > 0) ? $clog2(MIN_SEQS + 1) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LEFT   = 2'd1,
    RIGHT  = 2'd2,
    HAZARD = 2'd3
  } state_t;

  logic [NIN-1:0]  raw;
  logic [NIN-1:0]  sync_a;
  logic [NIN-1:0]  sync_b;
  logic [NIN-1:0]  db;
  logic [DB_W-1:0] db_cnt [NIN];

  logic db_left;
  logic db_right;
  logic db_hazard;
  logic db_brake;

  state_t            state;
  state_t            state_d;
  logic [STEP_W-1:0] step;
  logic [STEP_W-1:0] step_d;
  logic [CNT_W-1:0]  step_cnt;
  logic [CNT_W-1:0]  step_cnt_d;
  logic [SEQS_W-1:0] seqs;
  logic [SEQS_W-1:0] seqs_d;
  logic              seq_done;
  logic              min_pending;

  logic turn_left_q;
  logic turn_right_q;
  logic hazard_q;
  logic brake_q;

  assign raw       = {bus.raw_brake, bus.raw_hazard, bus.raw_right, bus.raw_left};
  assign db_left   = db[0];
  assign db_right  = db[1];
  assign db_hazard = db[2];
  assign db_brake  = db[3];

  // Two-flop synchroniser, then a run-length filter: db flips only after
  // DEBOUNCE_CYCLES consecutive synced samples that disagree with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a <= '0;
      sync_b <= '0;
      db     <= '0;
      for (int i = 0; i < NIN; i++) db_cnt[i] <= '0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
      for (int i = 0; i < NIN; i++) begin
        if (sync_b[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          db[i]     <= sync_b[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  assign seq_done    = (step == STEP_W'(STEPS - 1)) && (step_cnt == CNT_W'(STEP_CYCLES - 1));
  assign min_pending = (int'(seqs) + 1) < MIN_SEQS;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      step     <= '0;
      step_cnt <= '0;
      seqs     <= '0;
    end else begin
      state    <= state_d;
      step     <= step_d;
      step_cnt <= step_cnt_d;
      seqs     <= seqs_d;
    end
  end

  always_comb begin
    state_d    = state;
    step_d     = step;
    step_cnt_d = step_cnt;
    seqs_d     = seqs;

    case (state)
      IDLE: begin
        if (db_hazard)                  state_d = HAZARD;
        else if (db_left && !db_right)  state_d = LEFT;
        else if (db_right && !db_left)  state_d = RIGHT;
      end
      LEFT: begin
        if (db_hazard)
          state_d = HAZARD;
        else if (seq_done && !(db_left || min_pending))
          state_d = db_right ? RIGHT : IDLE;
      end
      RIGHT: begin
        if (db_hazard)
          state_d = HAZARD;
        else if (seq_done && !(db_right || min_pending))
          state_d = db_left ? LEFT : IDLE;
      end
      HAZARD: begin
        if (seq_done && !db_hazard) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Any state change restarts the sequence from step 0, which also makes
    // a LEFT/RIGHT handover land exactly on the sequence boundary.
    if ((state_d != state) || (state_d == IDLE)) begin
      step_d     = '0;
      step_cnt_d = '0;
      seqs_d     = '0;
    end else if (step_cnt == CNT_W'(STEP_CYCLES - 1)) begin
      step_cnt_d = '0;
      if (step == STEP_W'(STEPS - 1)) begin
        step_d = '0;
        if (seqs < SEQS_W'(MIN_SEQS)) seqs_d = seqs + SEQS_W'(1);
      end else begin
        step_d = step + STEP_W'(1);
      end
    end else begin
      step_cnt_d = step_cnt + CNT_W'(1);
    end
  end

  // Output registers load from the next state so they change on the same edge as the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      turn_left_q  <= 1'b0;
      turn_right_q <= 1'b0;
      hazard_q     <= 1'b0;
      brake_q      <= 1'b0;
    end else begin
      turn_left_q  <= (state_d == LEFT)  || (state_d == HAZARD);
      turn_right_q <= (state_d == RIGHT) || (state_d == HAZARD);
      hazard_q     <= (state_d == HAZARD);
      brake_q      <= db_brake;
    end
  end

  assign bus.turn_left     = turn_left_q;
  assign bus.turn_right    = turn_right_q;
  assign bus.hazard_active = hazard_q;
  assign bus.brake         = brake_q;
  assign bus.seq_phase     = step;

endmodule

// File: tb/tb_taillight_request_arbiter.sv
// Self-checking bench for taillight_request_arbiter: a history-based behavioural model
// checked every cycle, plus directed scenarios with hand-computed edge-exact expectations.
module tb_taillight_request_arbiter;

  localparam int DEB     = 4;
  localparam int SC      = 5;
  localparam int ST      = 4;
  localparam int MS      = 1;
  localparam int SEQ_LEN = SC * ST;

  localparam int M_IDLE  = 0;
  localparam int M_LEFT  = 1;
  localparam int M_RIGHT = 2;
  localparam int M_HAZ   = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  taillight_request_arbiter_if bus ();

  taillight_request_arbiter #(
    .DEBOUNCE_CYCLES(DEB),
    .STEP_CYCLES    (SC),
    .STEPS          (ST),
    .MIN_SEQS       (MS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Model state: raw sample history per input (index 0 = newest), debounced
  // values, FSM state as a plain integer and position within the 20-cycle sequence.
  bit hist [4][6];
  bit dbm  [4];
  bit dbo  [4];
  bit rawv [4];
  int mst, nst, mpos, mseqs;
  bit e_tl, e_tr, e_hz, e_br;
  int e_ph;

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int x = 0; x < 4; x++) begin
      for (int j = 0; j < 6; j++) hist[x][j] = 1'b0;
      dbm[x] = 1'b0;
    end
    mst = M_IDLE; mpos = 0; mseqs = 0;
    e_tl = 0; e_tr = 0; e_hz = 0; e_br = 0; e_ph = 0;
  endtask

  task automatic model_step();
    bit flip;
    rawv[0] = bus.raw_left;
    rawv[1] = bus.raw_right;
    rawv[2] = bus.raw_hazard;
    rawv[3] = bus.raw_brake;
    for (int x = 0; x < 4; x++) begin
      dbo[x] = dbm[x];
      for (int j = 5; j > 0; j--) hist[x][j] = hist[x][j-1];
      hist[x][0] = rawv[x];
      // synced value seen this edge is the raw sample from two edges ago
      flip = 1'b1;
      for (int j = 2; j < 2 + DEB; j++) if (hist[x][j] == dbm[x]) flip = 1'b0;
      if (flip) dbm[x] = !dbm[x];
    end
    nst = mst;
    case (mst)
      M_IDLE: begin
        if (dbo[2]) nst = M_HAZ;
        else if (dbo[0] && !dbo[1]) nst = M_LEFT;
        else if (dbo[1] && !dbo[0]) nst = M_RIGHT;
      end
      M_LEFT: begin
        if (dbo[2]) nst = M_HAZ;
        else if (mpos == SEQ_LEN - 1 && !(dbo[0] || (mseqs + 1 < MS)))
          nst = dbo[1] ? M_RIGHT : M_IDLE;
      end
      M_RIGHT: begin
        if (dbo[2]) nst = M_HAZ;
        else if (mpos == SEQ_LEN - 1 && !(dbo[1] || (mseqs + 1 < MS)))
          nst = dbo[0] ? M_LEFT : M_IDLE;
      end
      default: begin
        if (mpos == SEQ_LEN - 1 && !dbo[2]) nst = M_IDLE;
      end
    endcase
    if (nst != mst || nst == M_IDLE) begin
      mpos = 0; mseqs = 0;
    end else if (mpos == SEQ_LEN - 1) begin
      mpos = 0;
      if (mseqs < MS) mseqs++;
    end else begin
      mpos++;
    end
    mst  = nst;
    e_tl = (mst == M_LEFT)  || (mst == M_HAZ);
    e_tr = (mst == M_RIGHT) || (mst == M_HAZ);
    e_hz = (mst == M_HAZ);
    e_ph = mpos / SC;
    e_br = dbo[3];
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        cmp("model_turn_left",  8'(bus.turn_left),     8'(e_tl));
        cmp("model_turn_right", 8'(bus.turn_right),    8'(e_tr));
        cmp("model_hazard",     8'(bus.hazard_active), 8'(e_hz));
        cmp("model_brake",      8'(bus.brake),         8'(e_br));
        cmp("model_seq_phase",  8'(bus.seq_phase),     8'(e_ph));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cmp_all_zero(input string name);
    cmp({name, "_tl"}, 8'(bus.turn_left),     8'd0);
    cmp({name, "_tr"}, 8'(bus.turn_right),    8'd0);
    cmp({name, "_hz"}, 8'(bus.hazard_active), 8'd0);
    cmp({name, "_br"}, 8'(bus.brake),         8'd0);
    cmp({name, "_ph"}, 8'(bus.seq_phase),     8'd0);
  endtask

  int seen;
  int high_cnt;
  int first_hi;

  initial begin
    bus.raw_left = 0; bus.raw_right = 0; bus.raw_hazard = 0; bus.raw_brake = 0;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    chk_en = 1'b1;
    tick(3);
    cmp_all_zero("reset_state");

    // Left held: grant on edge 7, phase advances every 5 cycles and wraps
    bus.raw_left = 1;
    tick(6);  cmp("t2_e6_tl", 8'(bus.turn_left), 8'd0);
    tick(1);  cmp("t2_e7_tl", 8'(bus.turn_left), 8'd1);
              cmp("t2_e7_ph", 8'(bus.seq_phase), 8'd0);
    tick(4);  cmp("t2_e11_ph", 8'(bus.seq_phase), 8'd0);
    tick(1);  cmp("t2_e12_ph", 8'(bus.seq_phase), 8'd1);
    tick(5);  cmp("t2_e17_ph", 8'(bus.seq_phase), 8'd2);
    tick(5);  cmp("t2_e22_ph", 8'(bus.seq_phase), 8'd3);
    tick(5);  cmp("t2_e27_ph", 8'(bus.seq_phase), 8'd0);
              cmp("t2_e27_tl", 8'(bus.turn_left), 8'd1);
    tick(13); cmp("t2_e40_tl", 8'(bus.turn_left), 8'd1);

    // Asynchronous reset mid-sequence clears outputs without a clock edge
    #2;
    rst = 1'b1;
    bus.raw_left = 0;
    #1;
    cmp_all_zero("t1_async");
    tick(2);
    rst = 1'b0;
    tick(10);
    cmp_all_zero("t1_after");

    // Three-cycle glitch is filtered out
    bus.raw_left = 1;
    tick(3);
    bus.raw_left = 0;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      tick(1);
      if (bus.turn_left) seen++;
    end
    cmp("t3_glitch", 8'(seen), 8'd0);

    // Short press still yields exactly one whole sequence
    bus.raw_left = 1;
    high_cnt = 0;
    first_hi = 0;
    for (int i = 1; i <= 50; i++) begin
      tick(1);
      if (bus.turn_left) begin
        high_cnt++;
        if (first_hi == 0) first_hi = i;
      end
      if (i == 8) bus.raw_left = 0;
    end
    cmp("t4_first_edge", 8'(first_hi), 8'd7);
    cmp("t4_high_cycles", 8'(high_cnt), 8'd20);
    cmp("t4_end_ph", 8'(bus.seq_phase), 8'd0);

    // Left to right handover at the sequence boundary
    bus.raw_left = 1;
    tick(12);
    bus.raw_left = 0;
    bus.raw_right = 1;
    tick(14);
    cmp("t5_e26_tl", 8'(bus.turn_left),  8'd1);
    cmp("t5_e26_tr", 8'(bus.turn_right), 8'd0);
    tick(1);
    cmp("t5_e27_tl", 8'(bus.turn_left),  8'd0);
    cmp("t5_e27_tr", 8'(bus.turn_right), 8'd1);
    cmp("t5_e27_ph", 8'(bus.seq_phase),  8'd0);
    bus.raw_right = 0;
    tick(25);
    cmp_all_zero("t5_idle");

    // Hazard and brake override a running left sequence
    bus.raw_left = 1;
    tick(10);
    bus.raw_hazard = 1;
    bus.raw_brake = 1;
    tick(6);
    cmp("t6_h6_hz", 8'(bus.hazard_active), 8'd0);
    cmp("t6_h6_br", 8'(bus.brake),         8'd0);
    cmp("t6_h6_tl", 8'(bus.turn_left),     8'd1);
    cmp("t6_h6_tr", 8'(bus.turn_right),    8'd0);
    tick(1);
    cmp("t6_h7_tl", 8'(bus.turn_left),     8'd1);
    cmp("t6_h7_tr", 8'(bus.turn_right),    8'd1);
    cmp("t6_h7_hz", 8'(bus.hazard_active), 8'd1);
    cmp("t6_h7_br", 8'(bus.brake),         8'd1);
    cmp("t6_h7_ph", 8'(bus.seq_phase),     8'd0);
    bus.raw_left = 0;
    bus.raw_hazard = 0;
    bus.raw_brake = 0;
    tick(19);
    cmp("t6_h26_tl", 8'(bus.turn_left),     8'd1);
    cmp("t6_h26_tr", 8'(bus.turn_right),    8'd1);
    cmp("t6_h26_hz", 8'(bus.hazard_active), 8'd1);
    cmp("t6_h26_br", 8'(bus.brake),         8'd0);
    tick(1);
    cmp_all_zero("t6_h27");

    // Both stalks at once: no grant
    bus.raw_left = 1;
    bus.raw_right = 1;
    tick(15);
    cmp("t7_both_tl", 8'(bus.turn_left),  8'd0);
    cmp("t7_both_tr", 8'(bus.turn_right), 8'd0);
    bus.raw_left = 0;
    bus.raw_right = 0;
    tick(10);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
